// File: rtl/lsram_port_arbiter.sv
// Two-requester round-robin arbiter for one LSRAM port, with read data returned through a tag pipeline.
// Optional hold-grant lock for requester 0 is enabled with the LSRAM_ARB_LOCK_EN macro.
module lsram_port_arbiter #(
  parameter int MEM_AWIDTH = 16,
  parameter int DWIDTH     = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    rq0_req,
  input  logic                    rq0_write,
  input  logic [MEM_AWIDTH-1:0]   rq0_addr,
  input  logic [DWIDTH/8-1:0]     rq0_byteen,
  input  logic [DWIDTH-1:0]       rq0_wdata,
`ifdef LSRAM_ARB_LOCK_EN
  input  logic                    rq0_lock,
`endif
  output logic                    rq0_gnt,
  output logic                    rq0_rvalid,
  output logic [DWIDTH-1:0]       rq0_rdata,
  input  logic                    rq1_req,
  input  logic                    rq1_write,
  input  logic [MEM_AWIDTH-1:0]   rq1_addr,
  input  logic [DWIDTH/8-1:0]     rq1_byteen,
  input  logic [DWIDTH-1:0]       rq1_wdata,
  output logic                    rq1_gnt,
  output logic                    rq1_rvalid,
  output logic [DWIDTH-1:0]       rq1_rdata,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [MEM_AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH/8-1:0]     mem_byteen,
  output logic [DWIDTH-1:0]       mem_wdata,
  input  logic [DWIDTH-1:0]       mem_rdata
);

  localparam int BW = DWIDTH / 8;

  logic                  r_last_gnt;
  logic                  r_ren;
  logic                  r_wen;
  logic                  r_id;
  logic [MEM_AWIDTH-1:0] r_addr;
  logic [BW-1:0]         r_byteen;
  logic [DWIDTH-1:0]     r_wdata;
  logic [RD_LAT-1:0]     r_tag_v;
  logic [RD_LAT-1:0]     r_tag_id;

  logic                  w_lock_blk;
  logic                  w_req0;
  logic                  w_req1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_acc;
  logic                  w_write;
  logic [MEM_AWIDTH-1:0] w_addr;
  logic [BW-1:0]         w_byteen;
  logic [DWIDTH-1:0]     w_wdata;
  logic                  w_tag_v;
  logic                  w_tag_id;

`ifdef LSRAM_ARB_LOCK_EN
  logic r_lock;

  // Lock holds off requester 1 until requester 0 drops rq0_lock
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_lock <= 1'b0;
    end else if (r_lock && !rq0_lock) begin
      r_lock <= 1'b0;
    end else if (w_gnt0 && rq0_lock) begin
      r_lock <= 1'b1;
    end else begin
      r_lock <= r_lock;
    end
  end

  assign w_lock_blk = r_lock;
`else
  assign w_lock_blk = 1'b0;
`endif

  // r_last_gnt=1 means requester 1 was served last, so requester 0 wins a tie
  assign w_req0  = rq0_req & ~HRESET;
  assign w_req1  = rq1_req & ~HRESET & ~w_lock_blk;
  assign w_gnt0  = w_req0 & (~w_req1 | r_last_gnt);
  assign w_gnt1  = w_req1 & (~w_req0 | ~r_last_gnt);
  assign rq0_gnt = w_gnt0;
  assign rq1_gnt = w_gnt1;

  assign w_acc    = w_gnt0 | w_gnt1;
  assign w_write  = w_gnt1 ? rq1_write  : rq0_write;
  assign w_addr   = w_gnt1 ? rq1_addr   : rq0_addr;
  assign w_byteen = w_gnt1 ? rq1_byteen : rq0_byteen;
  assign w_wdata  = w_gnt1 ? rq1_wdata  : rq0_wdata;

  // Round-robin history
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_last_gnt <= 1'b1;
    end else if (w_acc) begin
      r_last_gnt <= w_gnt1;
    end
  end

  // Command register; address/byteen/wdata hold their value in idle cycles
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_id     <= 1'b0;
      r_addr   <= {MEM_AWIDTH{1'b0}};
      r_byteen <= {BW{1'b0}};
      r_wdata  <= {DWIDTH{1'b0}};
    end else begin
      r_ren <= w_acc & ~w_write;
      r_wen <= w_acc & w_write;
      if (w_acc) begin
        r_id     <= w_gnt1;
        r_addr   <= w_addr;
        r_byteen <= w_write ? w_byteen : {BW{1'b1}};
      end
      if (w_acc && w_write) begin
        r_wdata <= w_wdata;
      end
    end
  end

  // Read tags follow the issued command through RD_LAT stages
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_tag_v  <= {RD_LAT{1'b0}};
      r_tag_id <= {RD_LAT{1'b0}};
    end else begin
      r_tag_v[0]  <= r_ren;
      r_tag_id[0] <= r_id;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign w_tag_v  = r_tag_v[RD_LAT-1] & ~HRESET;
  assign w_tag_id = r_tag_id[RD_LAT-1];

  assign rq0_rvalid = w_tag_v & ~w_tag_id;
  assign rq1_rvalid = w_tag_v & w_tag_id;
  assign rq0_rdata  = rq0_rvalid ? mem_rdata : {DWIDTH{1'b0}};
  assign rq1_rdata  = rq1_rvalid ? mem_rdata : {DWIDTH{1'b0}};

  assign mem_ren    = r_ren;
  assign mem_wen    = r_wen;
  assign mem_addr   = r_addr;
  assign mem_byteen = r_byteen;
  assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_lsram_port_arbiter.sv
// Self-checking bench for lsram_port_arbiter: one instance at RD_LAT=1 and one at RD_LAT=2,
// each with its own behavioural LSRAM model, sharing stimulus.
module tb_lsram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 4;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic          HRESET;
  logic          rq0_req, rq0_write, rq1_req, rq1_write;
  logic [AW-1:0] rq0_addr, rq1_addr;
  logic [BW-1:0] rq0_byteen, rq1_byteen;
  logic [DW-1:0] rq0_wdata, rq1_wdata;
`ifdef LSRAM_ARB_LOCK_EN
  logic          rq0_lock;
`endif

  logic          a_rq0_gnt, a_rq0_rvalid, a_rq1_gnt, a_rq1_rvalid, a_mem_ren, a_mem_wen;
  logic [DW-1:0] a_rq0_rdata, a_rq1_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0] a_mem_addr;
  logic [BW-1:0] a_mem_byteen;
  logic          b_rq0_gnt, b_rq0_rvalid, b_rq1_gnt, b_rq1_rvalid, b_mem_ren, b_mem_wen;
  logic [DW-1:0] b_rq0_rdata, b_rq1_rdata, b_mem_wdata, b_mem_rdata, b_rd_stage;
  logic [AW-1:0] b_mem_addr;
  logic [BW-1:0] b_mem_byteen;

  lsram_port_arbiter #(.MEM_AWIDTH(AW), .DWIDTH(DW), .RD_LAT(1)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET),
    .rq0_req(rq0_req), .rq0_write(rq0_write), .rq0_addr(rq0_addr), .rq0_byteen(rq0_byteen),
    .rq0_wdata(rq0_wdata),
`ifdef LSRAM_ARB_LOCK_EN
    .rq0_lock(rq0_lock),
`endif
    .rq0_gnt(a_rq0_gnt), .rq0_rvalid(a_rq0_rvalid), .rq0_rdata(a_rq0_rdata),
    .rq1_req(rq1_req), .rq1_write(rq1_write), .rq1_addr(rq1_addr), .rq1_byteen(rq1_byteen),
    .rq1_wdata(rq1_wdata),
    .rq1_gnt(a_rq1_gnt), .rq1_rvalid(a_rq1_rvalid), .rq1_rdata(a_rq1_rdata),
    .mem_ren(a_mem_ren), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_byteen(a_mem_byteen),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  lsram_port_arbiter #(.MEM_AWIDTH(AW), .DWIDTH(DW), .RD_LAT(2)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET),
    .rq0_req(rq0_req), .rq0_write(rq0_write), .rq0_addr(rq0_addr), .rq0_byteen(rq0_byteen),
    .rq0_wdata(rq0_wdata),
`ifdef LSRAM_ARB_LOCK_EN
    .rq0_lock(rq0_lock),
`endif
    .rq0_gnt(b_rq0_gnt), .rq0_rvalid(b_rq0_rvalid), .rq0_rdata(b_rq0_rdata),
    .rq1_req(rq1_req), .rq1_write(rq1_write), .rq1_addr(rq1_addr), .rq1_byteen(rq1_byteen),
    .rq1_wdata(rq1_wdata),
    .rq1_gnt(b_rq1_gnt), .rq1_rvalid(b_rq1_rvalid), .rq1_rdata(b_rq1_rdata),
    .mem_ren(b_mem_ren), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_byteen(b_mem_byteen),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [31:0] due;
  } ret_t;

  ret_t qa[$];
  ret_t qb[$];

  logic [DW-1:0] mem_a  [256];
  logic [DW-1:0] mem_b  [256];
  logic [DW-1:0] shadow [256];

  logic          p_ren, p_wen;
  logic [AW-1:0] p_addr;
  logic [BW-1:0] p_be;
  logic [DW-1:0] p_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int k = 0; k < BW; k++) begin
      if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    end
    return r;
  endfunction

  always @(posedge HCLK) cyc <= cyc + 1;

  // LSRAM models: one-cycle and two-cycle read latency
  always @(posedge HCLK) begin
    if (a_mem_wen) mem_a[a_mem_addr[7:0]] <= merge(mem_a[a_mem_addr[7:0]], a_mem_wdata, a_mem_byteen);
    if (a_mem_ren) a_mem_rdata <= mem_a[a_mem_addr[7:0]];
  end

  always @(posedge HCLK) begin
    if (b_mem_wen) mem_b[b_mem_addr[7:0]] <= merge(mem_b[b_mem_addr[7:0]], b_mem_wdata, b_mem_byteen);
    if (b_mem_ren) b_rd_stage <= mem_b[b_mem_addr[7:0]];
    b_mem_rdata <= b_rd_stage;
  end

  task automatic ret_check(input string t, input logic v0, input logic v1, input logic [DW-1:0] d0,
                           input logic [DW-1:0] d1, input bit have, input ret_t e);
    chk({t, "_rvalid_onehot"}, {31'd0, v0 & v1}, 32'd0);
    if (!have) begin
      chk({t, "_rvalid_unexpected"}, {30'd0, v1, v0}, 32'd0);
    end else begin
      chk({t, "_ret_id"}, {31'd0, v1}, {31'd0, e.id});
      chk({t, "_ret_data"}, e.id ? d1 : d0, e.data);
      chk({t, "_ret_other_rdata"}, e.id ? d0 : d1, 32'd0);
      chk({t, "_ret_cycle"}, cyc, e.due);
    end
  endtask

  // Return monitors pop the scoreboards whenever any rvalid is seen
  always @(negedge HCLK) begin
    if (a_rq0_rvalid | a_rq1_rvalid) begin
      if (qa.size() == 0) ret_check("A", a_rq0_rvalid, a_rq1_rvalid, a_rq0_rdata, a_rq1_rdata, 1'b0, '0);
      else                ret_check("A", a_rq0_rvalid, a_rq1_rvalid, a_rq0_rdata, a_rq1_rdata, 1'b1, qa.pop_front());
    end
  end

  always @(negedge HCLK) begin
    if (b_rq0_rvalid | b_rq1_rvalid) begin
      if (qb.size() == 0) ret_check("B", b_rq0_rvalid, b_rq1_rvalid, b_rq0_rdata, b_rq1_rdata, 1'b0, '0);
      else                ret_check("B", b_rq0_rvalid, b_rq1_rvalid, b_rq0_rdata, b_rq1_rdata, 1'b1, qb.pop_front());
    end
  end

  // One bus cycle: check last cycle's command on mem_*, check grants, then predict the next command
  task automatic cycle(input logic eg0, input logic eg1, input string nm);
    logic          w;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    ret_t          e;
    @(negedge HCLK);
    chk({nm, "_mem_ren"},    {31'd0, a_mem_ren}, {31'd0, p_ren});
    chk({nm, "_mem_wen"},    {31'd0, a_mem_wen}, {31'd0, p_wen});
    chk({nm, "_mem_addr"},   {16'd0, a_mem_addr}, {16'd0, p_addr});
    chk({nm, "_mem_byteen"}, {28'd0, a_mem_byteen}, {28'd0, p_be});
    chk({nm, "_mem_wdata"},  a_mem_wdata, p_wd);
    chk({nm, "_b_mem_cmd"},  {14'd0, b_mem_ren, b_mem_wen, b_mem_addr}, {14'd0, p_ren, p_wen, p_addr});
    chk({nm, "_gnt"},   {30'd0, a_rq1_gnt, a_rq0_gnt}, {30'd0, eg1, eg0});
    chk({nm, "_b_gnt"}, {30'd0, b_rq1_gnt, b_rq0_gnt}, {30'd0, eg1, eg0});
    if (HRESET) begin
      qa.delete();
      qb.delete();
      p_ren = 1'b0; p_wen = 1'b0; p_addr = '0; p_be = '0; p_wd = '0;
    end else begin
      w  = eg1 ? rq1_write  : rq0_write;
      a  = eg1 ? rq1_addr   : rq0_addr;
      be = eg1 ? rq1_byteen : rq0_byteen;
      wd = eg1 ? rq1_wdata  : rq0_wdata;
      p_ren = (eg0 | eg1) & ~w;
      p_wen = (eg0 | eg1) & w;
      if (eg0 | eg1) begin
        p_addr = a;
        p_be   = w ? be : 4'b1111;
        if (w) begin
          p_wd = wd;
          shadow[a[7:0]] = merge(shadow[a[7:0]], wd, be);
        end else begin
          e.id = eg1; e.data = shadow[a[7:0]];
          e.due = cyc + 2; qa.push_back(e);
          e.due = cyc + 3; qb.push_back(e);
        end
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] be,
                      input logic [DW-1:0] wd);
    rq0_req = r; rq0_write = w; rq0_addr = a; rq0_byteen = be; rq0_wdata = wd;
  endtask

  task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] be,
                      input logic [DW-1:0] wd);
    rq1_req = r; rq1_write = w; rq1_addr = a; rq1_byteen = be; rq1_wdata = wd;
  endtask

  task automatic idle(input int n, input string nm);
    set0(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    set1(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, nm);
  endtask

  typedef struct {
    logic          r0;
    logic [AW-1:0] a0;
    logic          r1;
    logic [AW-1:0] a1;
    logic          g0;
    logic          g1;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // rq0 reads a0, rq1 writes 0xA5A5A5A5 with byteen 0011 to a1
    tbl[0]  = '{1'b1, 16'h0020, 1'b1, 16'h0030, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 16'h0021, 1'b1, 16'h0030, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 16'h0021, 1'b1, 16'h0031, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 16'h0022, 1'b1, 16'h0031, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 16'h0022, 1'b1, 16'h0032, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 16'h0023, 1'b1, 16'h0032, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 16'h0023, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 16'h0033, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'h0031, 1'b1, 16'h0034, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 16'h0034, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 16'h0034, 1'b1, 16'h0035, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 16'h0035, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) begin
      mem_a[i]  = 32'hC0DE0000 | i;
      mem_b[i]  = 32'hC0DE0000 | i;
      shadow[i] = 32'hC0DE0000 | i;
    end
    mem_a[16] = 32'hDEADBEEF; mem_b[16] = 32'hDEADBEEF; shadow[16] = 32'hDEADBEEF;
    p_ren = 1'b0; p_wen = 1'b0; p_addr = '0; p_be = '0; p_wd = '0;
`ifdef LSRAM_ARB_LOCK_EN
    rq0_lock = 1'b0;
`endif
    HRESET = 1'b1;
    set0(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    set1(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    @(posedge HCLK);
    #1;

    cycle(1'b0, 1'b0, "rst0");
    cycle(1'b0, 1'b0, "rst1");
    set0(1'b1, 1'b0, 16'h0005, 4'hF, 32'h0);
    set1(1'b1, 1'b1, 16'h0006, 4'hF, 32'h11111111);
    cycle(1'b0, 1'b0, "rst_req_blocked");
    HRESET = 1'b0;

    for (int i = 0; i < 13; i++) begin
      set0(tbl[i].r0, 1'b0, tbl[i].a0, 4'h0, 32'h0);
      set1(tbl[i].r1, 1'b1, tbl[i].a1, 4'b0011, 32'hA5A5A5A5);
      cycle(tbl[i].g0, tbl[i].g1, $sformatf("tbl%0d", i));
    end
    idle(3, "tbl_drain");

    set0(1'b1, 1'b0, 16'h0010, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, "rd_single");
    idle(4, "rd_single_idle");

    // Write right behind a read of the same word: read must see pre-write data
    set1(1'b1, 1'b0, 16'h0050, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, "war_rd");
    set1(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    set0(1'b1, 1'b1, 16'h0050, 4'b1100, 32'h12345678);
    cycle(1'b1, 1'b0, "war_wr");
    set0(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    set1(1'b1, 1'b0, 16'h0050, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, "war_rdback");
    idle(4, "war_idle");

    set1(1'b1, 1'b0, 16'h0001, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, "b2b_rq1");
    set1(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    set0(1'b1, 1'b0, 16'h0002, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, "b2b_rq0");
    idle(4, "b2b_idle");

    // Reset right after a read is accepted: no return may ever appear
    set0(1'b1, 1'b0, 16'h0010, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, "rstmid_rd");
    set0(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    HRESET = 1'b1;
    cycle(1'b0, 1'b0, "rstmid_a");
    cycle(1'b0, 1'b0, "rstmid_b");
    HRESET = 1'b0;
    idle(4, "rstmid_idle");
    set0(1'b1, 1'b0, 16'h0011, 4'h0, 32'h0);
    set1(1'b1, 1'b0, 16'h0012, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, "rst_first_contest");
    set0(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, "rst_second");
    idle(4, "rst_idle");

`ifdef LSRAM_ARB_LOCK_EN
    set1(1'b1, 1'b1, 16'h0070, 4'hF, 32'h77777777);
    rq0_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 1'b0, 16'h0060 + i[15:0], 4'h0, 32'h0);
      cycle(1'b1, 1'b0, $sformatf("lock%0d", i));
    end
    rq0_lock = 1'b0;
    set0(1'b0, 1'b0, 16'h0000, 4'h0, 32'h0);
    cycle(1'b0, 1'b0, "lock_release");
    cycle(1'b0, 1'b1, "lock_after");
    idle(4, "lock_idle");
`endif

    chk("scoreboard_a_drained", qa.size(), 32'd0);
    chk("scoreboard_b_drained", qb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
